pipe_lane_deskew: RTL and testbench
===================================

# pipe_lane_deskew

Multi-lane receive deskew buffer for the MAC side of the PIPE interface. It sits between the per-lane PHY receive outputs (`pipe_rxd`/`pipe_rxk`/`pipe_rxvalid` per lane) and the MAC receive logic. Each lane is buffered in its own FIFO, and lanes are aligned on a common alignment-marker word. The result is presented as one lane-synchronous word stream, and loss of alignment or overflow is flagged.

## Interface
- `NUM_LANES`, 2: number of receive lanes, 1–8.
- `DATA_BUS_WIDTH`, 32: per-lane data width in bits, one of 8/16/32.
- `DEPTH`, 8: per-lane FIFO depth in words, a power of 2 in the range 4–32.
- `ALIGN_SYM`, 8'hBC: alignment symbol (COM, K28.5).
- `clk` input, 1: PIPE clock.
- `areset` input, 1: reset, synchronous, active-low.
- `in_rxd` input, NUM_LANES*DATA_BUS_WIDTH: lane L occupies bits [L*DATA_BUS_WIDTH +: DATA_BUS_WIDTH].
- `in_rxk` input, NUM_LANES*DATA_BUS_WIDTH/8: per-byte K flags, packed the same way.
- `in_rxvalid` input, NUM_LANES: per-lane word valid.
- `out_rxd` output, NUM_LANES*DATA_BUS_WIDTH: aligned data, registered.
- `out_rxk` output, NUM_LANES*DATA_BUS_WIDTH/8: aligned K flags, registered.
- `out_valid` output, 1: `out_rxd`/`out_rxk` hold a lane-aligned word set.
- `aligned` output, 1: block is in ALIGNED.
- `deskew_err` output, 1: one-cycle pulse on timeout, overflow or misalignment.
- `skew_max` output, $clog2(DEPTH+1): present only under PIPE_DESKEW_STATS_EN.

## Operation
- **Marker definition:** a lane word whose byte 0 has K=1 and data == ALIGN_SYM.
- **FIFO write:** a lane's word is written into that lane's FIFO on every `clk` edge where its `in_rxvalid`=1.
- **States:** SEARCH (entered at reset) and ALIGNED.
- **SEARCH, per-lane pop rule:**
  - Head is not a marker: pop and discard it.
  - Head is a marker: hold it.
  - FIFO empty: no action.
- **SEARCH, wait counter `wcnt`:**
  - Starts at 1 in the first cycle any lane holds a marker.
  - Increments every cycle in which some lanes hold and others do not.
  - When `wcnt` reaches DEPTH: pulse `deskew_err`, flush all FIFOs, clear `wcnt`, stay in SEARCH.
- **SEARCH → ALIGNED:** when all heads are markers in the same cycle, pop all lanes, register the marker set with `out_valid`=1, and move to ALIGNED.
- **ALIGNED:**
  - All FIFOs non-empty: pop one word from every lane and register it with `out_valid`=1.
  - Otherwise: `out_valid`=0 and no lane pops.
- **Misalignment:** in ALIGNED, if the popped set contains a marker on some lanes but not all, pulse `deskew_err`, flush, and return to SEARCH. The faulty set is still output with `out_valid`=1.
- **Overflow:** a write to a full FIFO with no pop on that lane in the same cycle. In either state: pulse `deskew_err`, flush, go to SEARCH. The incoming word is dropped.
- **Full with simultaneous pop:** write and pop on the same lane in the same cycle are legal and are not overflow.
- **Flush:** all pointers and counts return to 0 at that edge. A write on the flush edge is discarded.
- **Pointer wrap:** pointers wrap modulo DEPTH. Each FIFO keeps a $clog2(DEPTH)+1-bit count to tell full from empty.
- **Priority when events coincide:** overflow > misalignment > timeout. Only one `deskew_err` pulse per cycle.

## Timing
- **Reset:** synchronous; applied at any `clk` edge with `areset`=0, including mid-operation. Values after reset:
  - `out_rxd`, `out_rxk`, `out_valid`, `aligned`, `deskew_err` = 0; `skew_max` = 0.
  - FIFOs empty, state SEARCH, `wcnt` = 0.
- **Latency:** a word written at edge N is at the FIFO head in cycle N+1. If popped at edge N+1, it appears on the outputs in cycle N+2. Minimum latency is 2 cycles.
- **`aligned`:** rises in the same cycle as the first marker output. Falls in the same cycle `deskew_err` pulses for misalignment or overflow.
- **Tolerated skew:** at most DEPTH-1 cycles between the first and last lane marker arrival.
- **Throughput:** one word set per cycle in ALIGNED when all lanes are continuously valid.

## Configuration
- **PIPE_DESKEW_STATS_EN defined:**
  - Adds the `skew_max` port.
  - On each SEARCH→ALIGNED transition, `skew_max` takes max(`skew_max`, `wcnt`), where `wcnt` = cycles between the first lane holding a marker and all lanes holding.
  - Cleared only by reset.
- **PIPE_DESKEW_STATS_EN undefined:** the `skew_max` port and its register are absent. All other behaviour is identical.

## Test plan
- **Reset:** hold `areset`=0 for 2 cycles with random inputs → all outputs 0, `aligned`=0. After release, `out_valid` stays 0 until a marker set arrives.
- **Zero skew** (NUM_LANES=2, DATA_BUS_WIDTH=32): marker on both lanes at cycle N, then data 1,2,3,4 → marker set on the outputs at N+2 with `aligned`=1, then data 1..4 on both lanes in cycles N+3..N+6.
- **Skew 3:** lane 0 marker at N, lane 1 marker at N+3, identical payloads → outputs lane-aligned from N+5. `skew_max`=3 under PIPE_DESKEW_STATS_EN.
- **Skew timeout:** DEPTH=8, lane 1 marker 9 cycles after lane 0 → one `deskew_err` pulse, `aligned` stays 0. A fresh zero-skew marker then aligns normally.
- **Misalignment/overflow:** in ALIGNED, lane 0 alone carries a marker → `deskew_err` pulse and `aligned`=0 in the cycle that set is output. Separately, stall lane 1 valid while lane 0 writes 9 words → overflow pulse.
- **Reset mid-stream:** assert `areset` while ALIGNED and streaming → outputs 0 on the next cycle. Realignment requires a new marker set.

Source files
------------

// File: rtl/pipe_lane_deskew.sv
// pipe_lane_deskew
//   Multi-lane receive deskew buffer between the per-lane PIPE PHY receive
//   outputs and the MAC receive logic. Every lane writes into its own FIFO.
//   In SEARCH, non-marker heads are dropped and marker heads are held until
//   all lanes show a marker at the same time. The block then moves to ALIGNED
//   and drains all lanes in lock-step. Overflow, misalignment and skew
//   timeout each flush every FIFO and return the block to SEARCH.
//
//   Optional feature macro: PIPE_DESKEW_STATS_EN (adds the skew_max port).
//
//   state      | meaning
//   -----------+-------------------------------------------------------------
//   ST_SEARCH  | drop non-marker heads, hold markers, wait for a full set
//   ST_ALIGNED | pop one word set per cycle whenever every lane has data
//
// Ports
//   clk         PIPE clock
//   areset      synchronous, active-low reset
//   in_rxd      per-lane receive data, lane L at [L*DATA_BUS_WIDTH +: DATA_BUS_WIDTH]
//   in_rxk      per-byte K flags, packed the same way
//   in_rxvalid  per-lane word valid
//   out_rxd     aligned data (registered)
//   out_rxk     aligned K flags (registered)
//   out_valid   out_rxd/out_rxk hold a lane-aligned word set
//   aligned     block is in ALIGNED
//   deskew_err  one-cycle pulse on overflow, misalignment or skew timeout
//   skew_max    largest skew seen at alignment (PIPE_DESKEW_STATS_EN only)

module pipe_lane_deskew #(
    parameter int          NUM_LANES      = 2,
    parameter int          DATA_BUS_WIDTH = 32,
    parameter int          DEPTH          = 8,
    parameter logic [7:0]  ALIGN_SYM      = 8'hBC
) (
    input  logic                                  clk,
    input  logic                                  areset,
    input  logic [NUM_LANES*DATA_BUS_WIDTH-1:0]   in_rxd,
    input  logic [NUM_LANES*DATA_BUS_WIDTH/8-1:0] in_rxk,
    input  logic [NUM_LANES-1:0]                  in_rxvalid,
    output logic [NUM_LANES*DATA_BUS_WIDTH-1:0]   out_rxd,
    output logic [NUM_LANES*DATA_BUS_WIDTH/8-1:0] out_rxk,
    output logic                                  out_valid,
    output logic                                  aligned,
    output logic                                  deskew_err
`ifdef PIPE_DESKEW_STATS_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0]            skew_max
`endif
);

    localparam int KW = DATA_BUS_WIDTH / 8;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = $clog2(DEPTH + 1);

    typedef enum logic {
        ST_SEARCH  = 1'b0,
        ST_ALIGNED = 1'b1
    } state_t;

    state_t state;
    logic [WW-1:0] wcnt;

    logic [DATA_BUS_WIDTH-1:0] mem_d [NUM_LANES][DEPTH];
    logic [KW-1:0]             mem_k [NUM_LANES][DEPTH];
    logic [AW-1:0]             wr_ptr [NUM_LANES];
    logic [AW-1:0]             rd_ptr [NUM_LANES];
    logic [CW-1:0]             count  [NUM_LANES];

    logic [DATA_BUS_WIDTH-1:0] head_d [NUM_LANES];
    logic [KW-1:0]             head_k [NUM_LANES];
    logic [NUM_LANES-1:0]      empty;
    logic [NUM_LANES-1:0]      full;
    logic [NUM_LANES-1:0]      head_mk;
    logic [NUM_LANES-1:0]      pop;
    logic [NUM_LANES-1:0]      push;
    logic [NUM_LANES-1:0]      ovf;
    logic                      all_mk;
    logic                      any_mk;
    logic                      all_ne;
    logic                      take;
    logic                      any_ovf;
    logic                      misalign;
    logic                      partial;
    logic                      timeout;
    logic                      flush;

    always_comb begin
        for (int l = 0; l < NUM_LANES; l++) begin
            head_d[l]  = mem_d[l][rd_ptr[l]];
            head_k[l]  = mem_k[l][rd_ptr[l]];
            empty[l]   = (count[l] == '0);
            full[l]    = (count[l] == CW'(DEPTH));
            head_mk[l] = !empty[l] && head_k[l][0] && (head_d[l][7:0] == ALIGN_SYM);
        end
        all_mk = &head_mk;
        any_mk = |head_mk;
        all_ne = ~|empty;

        // SEARCH takes only a complete marker set; ALIGNED takes any full set.
        take = (state == ST_SEARCH) ? all_mk : all_ne;

        pop = '0;
        if (take) begin
            pop = '1;
        end else if (state == ST_SEARCH) begin
            pop = ~empty & ~head_mk;
        end

        // A full lane that pops this cycle can still accept a write.
        ovf      = in_rxvalid & full & ~pop;
        any_ovf  = |ovf;
        push     = in_rxvalid & ~ovf;

        misalign = (state == ST_ALIGNED) && all_ne && any_mk && !all_mk;
        partial  = (state == ST_SEARCH) && any_mk && !all_mk;
        // wcnt counts completed partial-hold cycles, so this cycle is the DEPTH-th.
        timeout  = partial && (wcnt == WW'(DEPTH - 1));
        flush    = any_ovf || misalign || timeout;
    end

    always_ff @(posedge clk) begin
        for (int l = 0; l < NUM_LANES; l++) begin
            if (push[l] && !flush) begin
                mem_d[l][wr_ptr[l]] <= in_rxd[l*DATA_BUS_WIDTH +: DATA_BUS_WIDTH];
                mem_k[l][wr_ptr[l]] <= in_rxk[l*KW +: KW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!areset || flush) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                wr_ptr[l] <= '0;
                rd_ptr[l] <= '0;
                count[l]  <= '0;
            end
        end else begin
            for (int l = 0; l < NUM_LANES; l++) begin
                if (push[l]) begin
                    wr_ptr[l] <= wr_ptr[l] + AW'(1);
                end
                if (pop[l]) begin
                    rd_ptr[l] <= rd_ptr[l] + AW'(1);
                end
                case ({push[l], pop[l]})
                    2'b10:   count[l] <= count[l] + CW'(1);
                    2'b01:   count[l] <= count[l] - CW'(1);
                    default: count[l] <= count[l];
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!areset) begin
            state      <= ST_SEARCH;
            wcnt       <= '0;
            out_rxd    <= '0;
            out_rxk    <= '0;
            out_valid  <= 1'b0;
            aligned    <= 1'b0;
            deskew_err <= 1'b0;
`ifdef PIPE_DESKEW_STATS_EN
            skew_max   <= '0;
`endif
        end else begin
            deskew_err <= flush;
            out_valid  <= take;
            if (take) begin
                for (int l = 0; l < NUM_LANES; l++) begin
                    out_rxd[l*DATA_BUS_WIDTH +: DATA_BUS_WIDTH] <= head_d[l];
                    out_rxk[l*KW +: KW]                         <= head_k[l];
                end
            end

            case (state)
                ST_SEARCH: begin
                    if (any_ovf) begin
                        wcnt <= '0;
                    end else if (all_mk) begin
                        state   <= ST_ALIGNED;
                        aligned <= 1'b1;
                        wcnt    <= '0;
`ifdef PIPE_DESKEW_STATS_EN
                        if (wcnt > skew_max) begin
                            skew_max <= wcnt;
                        end
`endif
                    end else if (timeout) begin
                        wcnt <= '0;
                    end else if (partial) begin
                        wcnt <= wcnt + WW'(1);
                    end
                end
                ST_ALIGNED: begin
                    if (any_ovf || misalign) begin
                        state   <= ST_SEARCH;
                        aligned <= 1'b0;
                        wcnt    <= '0;
                    end
                end
                default: begin
                    state   <= ST_SEARCH;
                    aligned <= 1'b0;
                    wcnt    <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_lane_deskew.sv
// Directed bench for pipe_lane_deskew at NUM_LANES=2, DATA_BUS_WIDTH=32, DEPTH=8.
// Inputs change 1 ns after a rising edge; outputs are sampled at that point,
// so each check sees the registers loaded by the edge just taken.

module tb_pipe_lane_deskew;

    localparam logic [31:0] MK = 32'h0000_00BC;
    localparam logic [3:0]  KM = 4'b0001;

    logic        clk;
    logic        areset;
    logic [63:0] in_rxd;
    logic [7:0]  in_rxk;
    logic [1:0]  in_rxvalid;
    logic [63:0] out_rxd;
    logic [7:0]  out_rxk;
    logic        out_valid;
    logic        aligned;
    logic        deskew_err;
`ifdef PIPE_DESKEW_STATS_EN
    logic [3:0]  skew_max;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int n_err;

    pipe_lane_deskew #(
        .NUM_LANES      (2),
        .DATA_BUS_WIDTH (32),
        .DEPTH          (8),
        .ALIGN_SYM      (8'hBC)
    ) dut (
        .clk        (clk),
        .areset     (areset),
        .in_rxd     (in_rxd),
        .in_rxk     (in_rxk),
        .in_rxvalid (in_rxvalid),
        .out_rxd    (out_rxd),
        .out_rxk    (out_rxk),
        .out_valid  (out_valid),
        .aligned    (aligned),
        .deskew_err (deskew_err)
`ifdef PIPE_DESKEW_STATS_EN
        ,
        .skew_max   (skew_max)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v0, input logic [31:0] d0, input logic [3:0] k0,
                         input logic v1, input logic [31:0] d1, input logic [3:0] k1);
        in_rxvalid = {v1, v0};
        in_rxd     = {d1, d0};
        in_rxk     = {k1, k0};
    endtask

    task automatic idle();
        drive(1'b0, 32'd0, 4'd0, 1'b0, 32'd0, 4'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with random inputs
        areset     = 1'b0;
        in_rxd     = {$urandom, $urandom};
        in_rxk     = 8'($urandom);
        in_rxvalid = 2'($urandom);
        tick();
        in_rxd     = {$urandom, $urandom};
        tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_aligned", aligned, 0);
        chk("rst_err", deskew_err, 0);
        chk("rst_rxd", out_rxd, 0);
        chk("rst_rxk", out_rxk, 0);
`ifdef PIPE_DESKEW_STATS_EN
        chk("rst_skew_max", skew_max, 0);
`endif
        areset = 1'b1;
        idle();
        tick();
        tick();
        chk("post_rst_valid", out_valid, 0);

        // Zero skew: marker set then data 1..4
        drive(1, MK, KM, 1, MK, KM);
        tick();
        chk("zs_pre_valid", out_valid, 0);
        drive(1, 32'd1, 4'd0, 1, 32'd1, 4'd0);
        tick();
        chk("zs_mk_valid", out_valid, 1);
        chk("zs_mk_aligned", aligned, 1);
        chk("zs_mk_rxd", out_rxd, {MK, MK});
        chk("zs_mk_rxk", out_rxk, 8'h11);
        for (int i = 2; i <= 5; i++) begin
            if (i <= 4) drive(1, 32'(i), 4'd0, 1, 32'(i), 4'd0);
            else        idle();
            tick();
            chk("zs_data_valid", out_valid, 1);
            chk("zs_data_rxd", out_rxd, {32'(i - 1), 32'(i - 1)});
            chk("zs_data_rxk", out_rxk, 8'h00);
        end
        tick();
        chk("zs_drain_valid", out_valid, 0);
        chk("zs_drain_aligned", aligned, 1);

        // Misalignment: marker on lane 0 only
        drive(1, MK, KM, 1, 32'd5, 4'd0);
        tick();
        chk("mis_pre_valid", out_valid, 0);
        idle();
        tick();
        chk("mis_valid", out_valid, 1);
        chk("mis_err", deskew_err, 1);
        chk("mis_aligned", aligned, 0);
        chk("mis_rxd", out_rxd, {32'd5, MK});
        chk("mis_rxk", out_rxk, 8'h01);
        tick();
        chk("mis_err_clear", deskew_err, 0);
        chk("mis_valid_clear", out_valid, 0);

        // Skew 3: lane 0 marker at edge 0, lane 1 marker at edge 3
        for (int t = 0; t <= 11; t++) begin
            drive(t <= 6, (t == 0) ? MK : 32'(t), (t == 0) ? KM : 4'd0,
                  (t >= 3 && t <= 9), (t == 3) ? MK : 32'(t - 3), (t == 3) ? KM : 4'd0);
            tick();
            chk("sk3_valid", out_valid, (t >= 4 && t <= 10));
            chk("sk3_aligned", aligned, (t >= 4));
            if (t == 4) begin
                chk("sk3_mk_rxd", out_rxd, {MK, MK});
                chk("sk3_mk_rxk", out_rxk, 8'h11);
            end else if (t >= 5 && t <= 10) begin
                chk("sk3_data_rxd", out_rxd, {32'(t - 4), 32'(t - 4)});
            end
        end
        idle();
`ifdef PIPE_DESKEW_STATS_EN
        chk("sk3_skew_max", skew_max, 3);
`endif

        // Overflow: lane 1 stalled while lane 0 writes 9 words
        for (int t = 0; t <= 8; t++) begin
            drive(1, 32'(100 + t), 4'd0, 0, 32'd0, 4'd0);
            tick();
            chk("ovf_err", deskew_err, (t == 8));
            chk("ovf_aligned", aligned, (t != 8));
            chk("ovf_valid", out_valid, 0);
        end
        idle();
        tick();
        chk("ovf_err_clear", deskew_err, 0);

        // Skew timeout: lane 1 marker 9 cycles after lane 0
        n_err = 0;
        for (int t = 0; t <= 10; t++) begin
            drive(t == 0, MK, KM, t == 9, MK, KM);
            tick();
            if (deskew_err) n_err++;
            chk("to_err", deskew_err, (t == 8));
            chk("to_aligned", aligned, 0);
        end
        chk("to_err_count", 64'(n_err), 1);
        // The late lane-1 marker is held alone and times out on its own.
        n_err = 0;
        idle();
        for (int t = 0; t < 10; t++) begin
            tick();
            if (deskew_err) n_err++;
            chk("to_stale_aligned", aligned, 0);
        end
        chk("to_stale_err_count", 64'(n_err), 1);
        drive(1, MK, KM, 1, MK, KM);
        tick();
        chk("to_fresh_pre_valid", out_valid, 0);
        drive(1, 32'd7, 4'd0, 1, 32'd7, 4'd0);
        tick();
        chk("to_fresh_aligned", aligned, 1);
        chk("to_fresh_rxd", out_rxd, {MK, MK});
        chk("to_fresh_err", deskew_err, 0);
        idle();
        tick();
        chk("to_fresh_data", out_rxd, {32'd7, 32'd7});
        chk("to_fresh_valid", out_valid, 1);

        // Reset mid-stream
        drive(1, 32'd20, 4'd0, 1, 32'd20, 4'd0);
        tick();
        drive(1, 32'd21, 4'd0, 1, 32'd21, 4'd0);
        tick();
        chk("mrst_stream_rxd", out_rxd, {32'd20, 32'd20});
        drive(1, 32'd22, 4'd0, 1, 32'd22, 4'd0);
        areset = 1'b0;
        tick();
        chk("mrst_valid", out_valid, 0);
        chk("mrst_aligned", aligned, 0);
        chk("mrst_rxd", out_rxd, 0);
        chk("mrst_rxk", out_rxk, 0);
        chk("mrst_err", deskew_err, 0);
        areset = 1'b1;
        for (int t = 0; t < 3; t++) begin
            drive(1, 32'd23, 4'd0, 1, 32'd23, 4'd0);
            tick();
            chk("mrst_nomk_valid", out_valid, 0);
            chk("mrst_nomk_aligned", aligned, 0);
        end
        drive(1, MK, KM, 1, MK, KM);
        tick();
        drive(1, 32'd24, 4'd0, 1, 32'd24, 4'd0);
        tick();
        chk("mrst_realign", aligned, 1);
        chk("mrst_realign_rxd", out_rxd, {MK, MK});
        idle();
        tick();
        chk("mrst_data_rxd", out_rxd, {32'd24, 32'd24});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
